// File: rtl/dsp_be_mlse_pkg.sv
// Shared types and constants for the MLSE decision backend.
// Flag masks, controller states and unit bundles live here so every stage agrees on field order.
package dsp_be_mlse_pkg;

    localparam int FlagW = 8;

    typedef struct packed {
        logic p1a;
        logic p1b;
        logic p2;
        logic p3a;
        logic p3b;
        logic p3o;
        logic p4m;
        logic p4p;
    } flag_mask_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_RUN   = 2'd2,
        ST_FLUSH = 2'd3
    } mlse_ctrl_state_e;

    typedef struct packed {
        flag_mask_t flags;
        logic       vld;
    } flag_unit_t;

    typedef struct packed {
        logic signed [7:0] d0;
        logic signed [7:0] dm1;
        logic signed [7:0] dm2;
    } ari_unit_t;

endpackage

// File: rtl/dsp_be_sat_cnt.sv
// Saturating event counter with synchronous clear; clear beats a same-cycle increment.
// Single-cycle update, no backpressure.
module dsp_be_sat_cnt #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc_i,
    input  logic         clr_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/dsp_be_mlse_ctrl.sv
// Sequencer for the MLSE decision datapath: tap warm-up gating, flushed config apply, resync count.
// Config lands on the last flush edge; ack pulses the cycle after. Upstream valid is never stalled.
module dsp_be_mlse_ctrl
    import dsp_be_mlse_pkg::*;
#(
    parameter int WarmupCycles = 4,
    parameter int FlushCycles  = 2,
    parameter int CntW         = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_din_valid,
    input  logic             i_cfg_req,
    input  logic             i_cfg_mlse_en,
    input  logic [FlagW-1:0] i_cfg_flag_mask,
    input  logic             i_cnt_clr,
    output logic             o_cfg_ack,
    output logic             o_mlse_en,
    output logic [FlagW-1:0] o_flag_mask,
    output logic             o_dout_valid,
    output logic [1:0]       o_state,
    output logic [CntW-1:0]  o_resync_cnt
);

    localparam int CntMax = (WarmupCycles > FlushCycles) ? WarmupCycles : FlushCycles;
    localparam int PhW    = (CntMax > 1) ? $clog2(CntMax) : 1;
    localparam logic [PhW-1:0] WarmLoad  = PhW'(WarmupCycles - 1);
    localparam logic [PhW-1:0] FlushLoad = PhW'(FlushCycles - 1);

    mlse_ctrl_state_e state_q;
    logic [PhW-1:0]   cnt_q;
    logic             acked_q;
    logic             ack_q;
    logic             mlse_en_q;
    flag_mask_t       mask_q;

    logic new_req;
    logic resync_inc;

    assign new_req    = i_cfg_req & ~acked_q;
    assign resync_inc = (state_q == ST_RUN) & ~i_din_valid;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            acked_q   <= 1'b0;
            ack_q     <= 1'b0;
            mlse_en_q <= 1'b0;
            mask_q    <= '0;
        end else begin
            ack_q <= 1'b0;
            if (!i_cfg_req) begin
                acked_q <= 1'b0;
            end
            case (state_q)
                ST_IDLE: begin
                    if (new_req) begin
                        mlse_en_q <= i_cfg_mlse_en;
                        mask_q    <= i_cfg_flag_mask;
                        ack_q     <= 1'b1;
                        acked_q   <= 1'b1;
                    end else if (i_din_valid) begin
                        state_q <= ST_FILL;
                        cnt_q   <= WarmLoad;
                    end
                end
                ST_FILL: begin
                    if (new_req) begin
                        state_q <= ST_FLUSH;
                        cnt_q   <= FlushLoad;
                    end else if (!i_din_valid) begin
                        state_q <= ST_IDLE;
                    end else if (cnt_q == '0) begin
                        state_q <= ST_RUN;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_RUN: begin
                    if (new_req) begin
                        state_q <= ST_FLUSH;
                        cnt_q   <= FlushLoad;
                    end else if (!i_din_valid) begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_FLUSH: begin
                    // Output stays squashed until the last flush edge, where the new config lands.
                    if (cnt_q == '0) begin
                        mlse_en_q <= i_cfg_mlse_en;
                        mask_q    <= i_cfg_flag_mask;
                        ack_q     <= 1'b1;
                        acked_q   <= 1'b1;
                        state_q   <= i_din_valid ? ST_FILL : ST_IDLE;
                        cnt_q     <= WarmLoad;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    dsp_be_sat_cnt #(
        .W(CntW)
    ) u_resync_cnt (
        .clk_i (i_clk),
        .rst_i (i_rst),
        .inc_i (resync_inc),
        .clr_i (i_cnt_clr),
        .cnt_o (o_resync_cnt)
    );

    assign o_cfg_ack    = ack_q;
    assign o_mlse_en    = mlse_en_q;
    assign o_flag_mask  = mask_q;
    assign o_dout_valid = (state_q == ST_RUN);
    assign o_state      = state_q;

endmodule

// File: tb/tb_dsp_be_mlse_ctrl.sv
// Directed bench for dsp_be_mlse_ctrl: expectations queued at drive time, popped against DUT outputs.
module tb_dsp_be_mlse_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        vld;
    logic        req;
    logic        men;
    logic [7:0]  mask;
    logic        clr;

    logic        ack_a, men_a, dv_a;
    logic [7:0]  mask_a;
    logic [1:0]  st_a;
    logic [15:0] cnt_a;

    logic        ack_b, men_b, dv_b;
    logic [7:0]  mask_b;
    logic [1:0]  st_b;
    logic [1:0]  cnt_b;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    dsp_be_mlse_ctrl #(.WarmupCycles(4), .FlushCycles(2), .CntW(16)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_din_valid(vld), .i_cfg_req(req),
        .i_cfg_mlse_en(men), .i_cfg_flag_mask(mask), .i_cnt_clr(clr),
        .o_cfg_ack(ack_a), .o_mlse_en(men_a), .o_flag_mask(mask_a),
        .o_dout_valid(dv_a), .o_state(st_a), .o_resync_cnt(cnt_a)
    );

    dsp_be_mlse_ctrl #(.WarmupCycles(4), .FlushCycles(2), .CntW(2)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_din_valid(vld), .i_cfg_req(req),
        .i_cfg_mlse_en(men), .i_cfg_flag_mask(mask), .i_cnt_clr(clr),
        .o_cfg_ack(ack_b), .o_mlse_en(men_b), .o_flag_mask(mask_b),
        .o_dout_valid(dv_b), .o_state(st_b), .o_resync_cnt(cnt_b)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic pop_chk(input logic [31:0] obs);
        exp_t e;
        if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $error("FAIL scoreboard_empty observed=%0h expected=<entry>", obs);
        end else begin
            e = sb.pop_front();
            n_tests++;
            assert (obs === e.val) else begin
                n_fail++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
            end
        end
    endtask

    // Steps with valid high until dut_a reports RUN, bounded by a cycle budget.
    task automatic run_to_run();
        vld = 1'b1;
        for (int i = 0; i < 5; i++) step();
        push("reach_run", 32'd2);
        pop_chk({30'd0, st_a});
    endtask

    int acks;

    initial begin
        rst = 1'b1; vld = 1'b0; req = 1'b0; men = 1'b0; mask = 8'h00; clr = 1'b0;
        step(); step();

        // Reset state
        push("rst_state", 0);   pop_chk({30'd0, st_a});
        push("rst_men", 0);     pop_chk({31'd0, men_a});
        push("rst_mask", 0);    pop_chk({24'd0, mask_a});
        push("rst_dv", 0);      pop_chk({31'd0, dv_a});
        push("rst_ack", 0);     pop_chk({31'd0, ack_a});
        push("rst_cnt", 0);     pop_chk({16'd0, cnt_a});
        rst = 1'b0;

        // Warm-up: four FILL cycles, then RUN
        vld = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            push("fill_state", 1); pop_chk({30'd0, st_a});
            push("fill_dv", 0);    pop_chk({31'd0, dv_a});
        end
        step();
        push("run_state", 2); pop_chk({30'd0, st_a});
        push("run_dv", 1);    pop_chk({31'd0, dv_a});

        // Config change from RUN through FLUSH
        req = 1'b1; men = 1'b1; mask = 8'hA5;
        step();
        push("flush1_state", 3); pop_chk({30'd0, st_a});
        push("flush1_dv", 0);    pop_chk({31'd0, dv_a});
        push("flush1_ack", 0);   pop_chk({31'd0, ack_a});
        step();
        push("flush2_state", 3); pop_chk({30'd0, st_a});
        push("flush2_ack", 0);   pop_chk({31'd0, ack_a});
        step();
        push("apply_ack", 1);    pop_chk({31'd0, ack_a});
        push("apply_state", 1);  pop_chk({30'd0, st_a});
        push("apply_mask", 32'hA5); pop_chk({24'd0, mask_a});
        push("apply_men", 1);    pop_chk({31'd0, men_a});
        acks = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (ack_a) acks++;
        end
        push("held_req_acks", 0);   pop_chk(acks);
        push("held_req_state", 2);  pop_chk({30'd0, st_a});
        push("held_req_mask", 32'hA5); pop_chk({24'd0, mask_a});
        req = 1'b0;

        // Drop to IDLE with a same-cycle clear: clear wins
        vld = 1'b0; clr = 1'b1;
        step();
        push("clr_win_state", 0); pop_chk({30'd0, st_a});
        push("clr_win_cnt", 0);   pop_chk({16'd0, cnt_a});
        clr = 1'b0;

        // Config in IDLE with no valid
        req = 1'b1; men = 1'b0; mask = 8'h0F;
        step();
        push("idle_ack", 1);      pop_chk({31'd0, ack_a});
        push("idle_state", 0);    pop_chk({30'd0, st_a});
        push("idle_mask", 32'h0F); pop_chk({24'd0, mask_a});
        push("idle_men", 0);      pop_chk({31'd0, men_a});
        step();
        push("idle_ack_pulse", 0); pop_chk({31'd0, ack_a});
        push("idle_stay", 0);      pop_chk({30'd0, st_a});
        req = 1'b0;
        step();

        // Three RUN drops
        for (int k = 1; k <= 3; k++) begin
            run_to_run();
            vld = 1'b0;
            step();
            push("drop_state", 0); pop_chk({30'd0, st_a});
            push("drop_cnt", k);   pop_chk({16'd0, cnt_a});
        end
        push("drop_cnt_w2", 3); pop_chk({30'd0, cnt_b});
        // Drop during FILL is not a resync
        vld = 1'b1; step();
        vld = 1'b0; step();
        push("fill_drop_state", 0); pop_chk({30'd0, st_a});
        push("fill_drop_cnt", 3);   pop_chk({16'd0, cnt_a});

        // Saturation on the narrow counter
        for (int k = 0; k < 2; k++) begin
            run_to_run();
            vld = 1'b0;
            step();
        end
        push("sat_cnt_w16", 5); pop_chk({16'd0, cnt_a});
        push("sat_cnt_w2", 3);  pop_chk({30'd0, cnt_b});
        run_to_run();
        vld = 1'b0; clr = 1'b1;
        step();
        push("clr_drop_w16", 0); pop_chk({16'd0, cnt_a});
        push("clr_drop_w2", 0);  pop_chk({30'd0, cnt_b});
        clr = 1'b0;

        // Reset during FLUSH aborts, held request is then served from IDLE
        run_to_run();
        req = 1'b1; men = 1'b1; mask = 8'h3C;
        step();
        push("pre_rst_flush", 3); pop_chk({30'd0, st_a});
        rst = 1'b1;
        step();
        push("mid_rst_state", 0); pop_chk({30'd0, st_a});
        push("mid_rst_ack", 0);   pop_chk({31'd0, ack_a});
        push("mid_rst_mask", 0);  pop_chk({24'd0, mask_a});
        push("mid_rst_men", 0);   pop_chk({31'd0, men_a});
        push("mid_rst_dv", 0);    pop_chk({31'd0, dv_a});
        rst = 1'b0;
        step();
        push("post_rst_ack", 1);     pop_chk({31'd0, ack_a});
        push("post_rst_state", 0);   pop_chk({30'd0, st_a});
        push("post_rst_mask", 32'h3C); pop_chk({24'd0, mask_a});
        step();
        push("post_rst_ack_off", 0); pop_chk({31'd0, ack_a});
        push("post_rst_fill", 1);    pop_chk({30'd0, st_a});
        req = 1'b0;

        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
